// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - Tomasulo reservation station with CDB snoop and FU dispatch.
// Optional RS_ISSUE_BYPASS_EN: capture a same-cycle CDB broadcast into an operand being issued.
module reservation_station #(
  parameter int DEPTH    = 4,
  parameter int TAG_W    = 5,
  parameter int DATA_W   = 32,
  parameter int OP_W     = 4,
  parameter int TAG_BASE = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_issue_valid,
  output logic                         out_issue_ready,
  input  logic [OP_W-1:0]              in_issue_op,
  input  logic [DATA_W-1:0]            in_val_1,
  input  logic [DATA_W-1:0]            in_val_2,
  input  logic [TAG_W-1:0]             in_tag_1,
  input  logic [TAG_W-1:0]             in_tag_2,
  output logic [TAG_W-1:0]             out_alloc_tag,
  input  logic                         in_CDB_broadcast,
  input  logic [TAG_W-1:0]             in_CDB_tag,
  input  logic [DATA_W-1:0]            in_CDB_val,
  output logic                         out_disp_valid,
  input  logic                         in_disp_ready,
  output logic [OP_W-1:0]              out_disp_op,
  output logic [DATA_W-1:0]            out_disp_val_1,
  output logic [DATA_W-1:0]            out_disp_val_2,
  output logic [TAG_W-1:0]             out_disp_tag,
  output logic [$clog2(DEPTH+1)-1:0]   out_count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0]  busy;
  logic [OP_W-1:0]   op_q [DEPTH];
  logic [DATA_W-1:0] v1_q [DEPTH];
  logic [DATA_W-1:0] v2_q [DEPTH];
  logic [TAG_W-1:0]  q1_q [DEPTH];
  logic [TAG_W-1:0]  q2_q [DEPTH];

  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic             rdy_found;
  logic [IDX_W-1:0] rdy_idx;
  logic [CNT_W-1:0] busy_cnt;
  logic             issue;
  logic             disp;
  logic             cdb_hit;
  logic             byp_1;
  logic             byp_2;

  // Scanning from the top down leaves the lowest matching index in place.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    rdy_found  = 1'b0;
    rdy_idx    = '0;
    busy_cnt   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (busy[i] && (q1_q[i] == '0) && (q2_q[i] == '0)) begin
        rdy_found = 1'b1;
        rdy_idx   = IDX_W'(i);
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      busy_cnt = busy_cnt + CNT_W'(busy[i]);
    end
  end

  assign issue   = in_issue_valid && free_found;
  assign disp    = rdy_found && in_disp_ready;
  assign cdb_hit = in_CDB_broadcast && (in_CDB_tag != '0);

`ifdef RS_ISSUE_BYPASS_EN
  assign byp_1 = cdb_hit && (in_tag_1 == in_CDB_tag);
  assign byp_2 = cdb_hit && (in_tag_2 == in_CDB_tag);
`else
  assign byp_1 = 1'b0;
  assign byp_2 = 1'b0;
`endif

  assign out_issue_ready = free_found;
  assign out_alloc_tag   = free_found ? (TAG_W'(TAG_BASE) + TAG_W'(free_idx)) : '0;
  assign out_count       = busy_cnt;

  // Dispatch fields come only from registers, so a CDB capture is visible a cycle later.
  assign out_disp_valid = rdy_found;
  assign out_disp_op    = rdy_found ? op_q[rdy_idx] : '0;
  assign out_disp_val_1 = rdy_found ? v1_q[rdy_idx] : '0;
  assign out_disp_val_2 = rdy_found ? v2_q[rdy_idx] : '0;
  assign out_disp_tag   = rdy_found ? (TAG_W'(TAG_BASE) + TAG_W'(rdy_idx)) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i] <= '0;
        v1_q[i] <= '0;
        v2_q[i] <= '0;
        q1_q[i] <= '0;
        q2_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (issue && (free_idx == IDX_W'(i))) begin
          busy[i] <= 1'b1;
          op_q[i] <= in_issue_op;
          v1_q[i] <= byp_1 ? in_CDB_val : in_val_1;
          q1_q[i] <= byp_1 ? '0 : in_tag_1;
          v2_q[i] <= byp_2 ? in_CDB_val : in_val_2;
          q2_q[i] <= byp_2 ? '0 : in_tag_2;
        end else if (busy[i]) begin
          if (disp && (rdy_idx == IDX_W'(i))) begin
            busy[i] <= 1'b0;
          end
          if (cdb_hit && (q1_q[i] == in_CDB_tag)) begin
            v1_q[i] <= in_CDB_val;
            q1_q[i] <= '0;
          end
          if (cdb_hit && (q2_q[i] == in_CDB_tag)) begin
            v2_q[i] <= in_CDB_val;
            q2_q[i] <= '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// tb/tb_reservation_station.sv - Directed and randomized checks of reservation_station against a queue-free array model.
module tb_reservation_station;

  localparam int DEPTH    = 4;
  localparam int TAG_W    = 5;
  localparam int DATA_W   = 32;
  localparam int OP_W     = 4;
  localparam int TAG_BASE = 1;
  localparam int CNT_W    = $clog2(DEPTH + 1);

  logic              clk;
  logic              rst;
  logic              iv;
  logic              issue_ready;
  logic [OP_W-1:0]   iop;
  logic [DATA_W-1:0] v1, v2;
  logic [TAG_W-1:0]  t1, t2;
  logic [TAG_W-1:0]  alloc_tag;
  logic              cb;
  logic [TAG_W-1:0]  ct;
  logic [DATA_W-1:0] cv;
  logic              disp_valid;
  logic              dr;
  logic [OP_W-1:0]   disp_op;
  logic [DATA_W-1:0] disp_v1, disp_v2;
  logic [TAG_W-1:0]  disp_tag;
  logic [CNT_W-1:0]  count;

  int checks = 0;
  int errors = 0;

  bit                m_busy [DEPTH];
  logic [OP_W-1:0]   m_op   [DEPTH];
  logic [DATA_W-1:0] m_v1   [DEPTH];
  logic [DATA_W-1:0] m_v2   [DEPTH];
  logic [TAG_W-1:0]  m_q1   [DEPTH];
  logic [TAG_W-1:0]  m_q2   [DEPTH];

  reservation_station #(
    .DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .OP_W(OP_W), .TAG_BASE(TAG_BASE)
  ) dut (
    .clk(clk), .rst(rst),
    .in_issue_valid(iv), .out_issue_ready(issue_ready), .in_issue_op(iop),
    .in_val_1(v1), .in_val_2(v2), .in_tag_1(t1), .in_tag_2(t2),
    .out_alloc_tag(alloc_tag),
    .in_CDB_broadcast(cb), .in_CDB_tag(ct), .in_CDB_val(cv),
    .out_disp_valid(disp_valid), .in_disp_ready(dr), .out_disp_op(disp_op),
    .out_disp_val_1(disp_v1), .out_disp_val_2(disp_v2), .out_disp_tag(disp_tag),
    .out_count(count)
  );

  always #5 clk = ~clk;

  function automatic int lowest_free();
    for (int i = 0; i < DEPTH; i++) if (!m_busy[i]) return i;
    return -1;
  endfunction

  function automatic int lowest_ready();
    for (int i = 0; i < DEPTH; i++)
      if (m_busy[i] && m_q1[i] == 0 && m_q2[i] == 0) return i;
    return -1;
  endfunction

  task automatic idle();
    rst = 0; iv = 0; iop = 0; v1 = 0; v2 = 0; t1 = 0; t2 = 0;
    cb = 0; ct = 0; cv = 0; dr = 0;
  endtask

  // Advances one clock: model next state from the current inputs, then clears inputs.
  task automatic tick();
    bit                nb  [DEPTH];
    logic [OP_W-1:0]   nop [DEPTH];
    logic [DATA_W-1:0] nv1 [DEPTH];
    logic [DATA_W-1:0] nv2 [DEPTH];
    logic [TAG_W-1:0]  nq1 [DEPTH];
    logic [TAG_W-1:0]  nq2 [DEPTH];
    int fi, ri;
    bit hit;
    fi = lowest_free();
    ri = lowest_ready();
    hit = cb && (ct != 0);
    for (int i = 0; i < DEPTH; i++) begin
      nb[i] = m_busy[i]; nop[i] = m_op[i];
      nv1[i] = m_v1[i]; nv2[i] = m_v2[i]; nq1[i] = m_q1[i]; nq2[i] = m_q2[i];
      if (m_busy[i] && hit && m_q1[i] == ct) begin nv1[i] = cv; nq1[i] = 0; end
      if (m_busy[i] && hit && m_q2[i] == ct) begin nv2[i] = cv; nq2[i] = 0; end
    end
    if (ri >= 0 && dr) nb[ri] = 0;
    if (iv && fi >= 0) begin
      nb[fi] = 1; nop[fi] = iop;
      nv1[fi] = v1; nq1[fi] = t1; nv2[fi] = v2; nq2[fi] = t2;
`ifdef RS_ISSUE_BYPASS_EN
      if (hit && t1 == ct) begin nv1[fi] = cv; nq1[fi] = 0; end
      if (hit && t2 == ct) begin nv2[fi] = cv; nq2[fi] = 0; end
`endif
    end
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        nb[i] = 0; nop[i] = 0; nv1[i] = 0; nv2[i] = 0; nq1[i] = 0; nq2[i] = 0;
      end
    end
    @(posedge clk);
    for (int i = 0; i < DEPTH; i++) begin
      m_busy[i] = nb[i]; m_op[i] = nop[i];
      m_v1[i] = nv1[i]; m_v2[i] = nv2[i]; m_q1[i] = nq1[i]; m_q2[i] = nq2[i];
    end
    @(negedge clk);
    idle();
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0h expected 1", issue_ready); end
    checks++; if (alloc_tag !== 5'd1) begin errors++; $display("FAIL reset_alloc: got %0h expected 1", alloc_tag); end
    checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL reset_disp_valid: got %0h expected 0", disp_valid); end
    checks++; if ({disp_op, disp_v1, disp_v2, disp_tag} !== '0) begin errors++; $display("FAIL reset_disp_fields: got %0h/%0h/%0h/%0h expected 0", disp_op, disp_v1, disp_v2, disp_tag); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
  endtask

  task automatic test_basic_dispatch();
    do_reset();
    iv = 1; iop = 3; v1 = 10; v2 = 20; t1 = 0; t2 = 0;
    #1;
    checks++; if (alloc_tag !== 5'd1) begin errors++; $display("FAIL basic_alloc: got %0h expected 1", alloc_tag); end
    tick();
    #1;
    checks++; if (disp_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %0h expected 1", disp_valid); end
    checks++; if (disp_op !== 4'd3 || disp_v1 !== 32'd10 || disp_v2 !== 32'd20) begin errors++; $display("FAIL basic_fields: got %0h/%0d/%0d expected 3/10/20", disp_op, disp_v1, disp_v2); end
    checks++; if (disp_tag !== 5'd1 || count !== 3'd1) begin errors++; $display("FAIL basic_tag_count: got %0h/%0d expected 1/1", disp_tag, count); end
    dr = 1;
    tick();
    #1;
    checks++; if (count !== 3'd0 || disp_valid !== 1'b0) begin errors++; $display("FAIL basic_drain: got count %0d valid %0h expected 0/0", count, disp_valid); end
  endtask

  task automatic test_cdb_capture();
    do_reset();
    iv = 1; iop = 5; t1 = 7; v2 = 5;
    tick();
    #1;
    checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL cdb_pending: got %0h expected 0", disp_valid); end
    cb = 1; ct = 0; cv = 9;
    tick();
    #1;
    checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL cdb_tag0_ignored: got %0h expected 0", disp_valid); end
    cb = 1; ct = 7; cv = 32'h111;
    #1;
    checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL cdb_no_comb_path: got %0h expected 0", disp_valid); end
    tick();
    #1;
    checks++; if (disp_valid !== 1'b1 || disp_v1 !== 32'h111 || disp_v2 !== 32'd5) begin errors++; $display("FAIL cdb_capture: got %0h/%0h/%0h expected 1/111/5", disp_valid, disp_v1, disp_v2); end
  endtask

  task automatic test_fill_order();
    do_reset();
    for (int k = 0; k < DEPTH; k++) begin
      iv = 1; iop = OP_W'(k); t1 = 9; v2 = k;
      #1;
      checks++; if (alloc_tag !== TAG_W'(k + 1)) begin errors++; $display("FAIL fill_alloc%0d: got %0d expected %0d", k, alloc_tag, k + 1); end
      tick();
    end
    #1;
    checks++; if (issue_ready !== 1'b0 || alloc_tag !== 5'd0 || count !== 3'd4) begin errors++; $display("FAIL full_state: got %0h/%0d/%0d expected 0/0/4", issue_ready, alloc_tag, count); end
    iv = 1; iop = 15; t1 = 9;
    tick();
    #1;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_ignore: got %0d expected 4", count); end
    cb = 1; ct = 9; cv = 32'habc;
    tick();
    for (int k = 0; k < DEPTH; k++) begin
      dr = 1;
      #1;
      checks++; if (disp_valid !== 1'b1 || disp_tag !== TAG_W'(k + 1) || disp_v1 !== 32'habc || disp_op !== OP_W'(k)) begin errors++; $display("FAIL order%0d: got v%0h tag %0d val %0h op %0d expected tag %0d", k, disp_valid, disp_tag, disp_v1, disp_op, k + 1); end
      tick();
    end
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL order_drain: got %0d expected 0", count); end
  endtask

  task automatic test_full_dispatch_issue();
    do_reset();
    for (int k = 0; k < DEPTH; k++) begin
      iv = 1; iop = 1; v1 = k;
      tick();
    end
    iv = 1; iop = 2; dr = 1;
    #1;
    checks++; if (issue_ready !== 1'b0 || disp_tag !== 5'd1) begin errors++; $display("FAIL full_disp_cycle: got %0h/%0d expected 0/1", issue_ready, disp_tag); end
    tick();
    #1;
    checks++; if (count !== 3'd3 || issue_ready !== 1'b1 || alloc_tag !== 5'd1) begin errors++; $display("FAIL full_disp_next: got %0d/%0h/%0d expected 3/1/1", count, issue_ready, alloc_tag); end
  endtask

  task automatic test_issue_bypass();
    do_reset();
    iv = 1; iop = 4; t1 = 6; v2 = 3; cb = 1; ct = 6; cv = 42;
    tick();
    #1;
`ifdef RS_ISSUE_BYPASS_EN
    checks++; if (disp_valid !== 1'b1 || disp_v1 !== 32'd42) begin errors++; $display("FAIL bypass: got %0h/%0d expected 1/42", disp_valid, disp_v1); end
`else
    checks++; if (disp_valid !== 1'b0 || count !== 3'd1) begin errors++; $display("FAIL no_bypass: got %0h/%0d expected 0/1", disp_valid, count); end
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      iv = 1; iop = 7; v1 = k;
      tick();
    end
    rst = 1; iv = 1; dr = 1;
    tick();
    #1;
    checks++; if (count !== 3'd0 || disp_valid !== 1'b0 || alloc_tag !== 5'd1) begin errors++; $display("FAIL reset_mid: got %0d/%0h/%0d expected 0/0/1", count, disp_valid, alloc_tag); end
  endtask

  task automatic test_random();
    int fi, ri, cnt;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      iv  = $urandom_range(0, 1);
      iop = OP_W'($urandom);
      v1  = $urandom; v2 = $urandom;
      t1  = ($urandom_range(0, 2) == 0) ? '0 : TAG_W'($urandom_range(1, 6));
      t2  = ($urandom_range(0, 2) == 0) ? '0 : TAG_W'($urandom_range(1, 6));
      cb  = $urandom_range(0, 1);
      ct  = TAG_W'($urandom_range(0, 6));
      cv  = $urandom;
      dr  = ($urandom_range(0, 9) < 6);
      #1;
      fi = lowest_free();
      ri = lowest_ready();
      cnt = 0;
      for (int i = 0; i < DEPTH; i++) cnt += m_busy[i];
      checks++; if (issue_ready !== (fi >= 0)) begin errors++; $display("FAIL rnd%0d_ready: got %0h expected %0h", n, issue_ready, fi >= 0); end
      checks++; if (alloc_tag !== ((fi >= 0) ? TAG_W'(TAG_BASE + fi) : TAG_W'(0))) begin errors++; $display("FAIL rnd%0d_alloc: got %0d expected free idx %0d", n, alloc_tag, fi); end
      checks++; if (count !== CNT_W'(cnt)) begin errors++; $display("FAIL rnd%0d_count: got %0d expected %0d", n, count, cnt); end
      checks++; if (disp_valid !== (ri >= 0)) begin errors++; $display("FAIL rnd%0d_disp_valid: got %0h expected %0h", n, disp_valid, ri >= 0); end
      if (ri >= 0) begin
        checks++;
        if (disp_tag !== TAG_W'(TAG_BASE + ri) || disp_op !== m_op[ri] || disp_v1 !== m_v1[ri] || disp_v2 !== m_v2[ri]) begin
          errors++;
          $display("FAIL rnd%0d_disp: got tag %0d op %0h %0h/%0h expected tag %0d op %0h %0h/%0h", n, disp_tag, disp_op, disp_v1, disp_v2, TAG_BASE + ri, m_op[ri], m_v1[ri], m_v2[ri]);
        end
      end
      tick();
    end
  endtask

  initial begin
    clk = 0;
    idle();
    @(negedge clk);
    test_reset();
    test_basic_dispatch();
    test_cdb_capture();
    test_fill_order();
    test_full_dispatch_issue();
    test_issue_bypass();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
